// File: rtl/lcd_byte_arbiter_pkg.sv
// Shared types and constants for the two-port byte arbiter in front of the 4-bit LCD controller.
package lcd_byte_arbiter_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHiWr,
    StHiGap,
    StLoWr,
    StLoGap,
    StDone
  } arb_state_e;

  localparam logic LcdReqCpu = 1'b0;
  localparam logic LcdReqAux = 1'b1;

  localparam int unsigned DefGapNibble     = 50;
  localparam int unsigned DefGapByte       = 2000;
  localparam int unsigned DefTimeoutCycles = 4096;

  // Counter must hold the largest preload value; never narrower than one bit.
  function automatic int unsigned cnt_width(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m == 0) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/lcd_byte_arbiter_gap_timer.sv
// Loadable down-counter that saturates at zero; shared by the nibble gap, byte gap and timeout.
module lcd_byte_arbiter_gap_timer
  import lcd_byte_arbiter_pkg::*;
#(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] value_i,
  output logic             expired_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_byte_arbiter.sv
// Round-robin arbiter sending one byte as two nibbles to the LCD controller, with gaps and ack.
// Optional write timeout enabled by defining LCD_ARB_TIMEOUT_EN.
module lcd_byte_arbiter
  import lcd_byte_arbiter_pkg::*;
#(
  parameter int unsigned GapNibble     = DefGapNibble,
  parameter int unsigned GapByte       = DefGapByte,
  parameter int unsigned TimeoutCycles = DefTimeoutCycles
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic [7:0] data0_i,
  input  logic [7:0] data1_i,
  input  logic       rs0_i,
  input  logic       rs1_i,
  output logic       ack0_o,
  output logic       ack1_o,
  output logic       grant_o,
  output logic       busy_o,
  output logic [3:0] lcd_data_o,
  output logic       lcd_rs_o,
  output logic       lcd_write_en_o,
  input  logic       lcd_response_i,
  output logic       timeout_o
);

  localparam int unsigned CntW = cnt_width(GapNibble, GapByte, TimeoutCycles);
  localparam logic [CntW-1:0] GapNibbleV = CntW'(GapNibble);
  localparam logic [CntW-1:0] GapByteV   = CntW'(GapByte);

  arb_state_e  state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_q, last_d;
  logic [7:0]  data_q, data_d;
  logic        rs_q, rs_d;
  logic        busy_q, busy_d;
  logic        we_q, we_d;
  logic [3:0]  nib_q, nib_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic        pick;
  logic [7:0]  sel_data;
  logic            tmr_load;
  logic [CntW-1:0] tmr_value;
  logic            tmr_expired;

`ifdef LCD_ARB_TIMEOUT_EN
  localparam logic [CntW-1:0] TimeoutV = CntW'(TimeoutCycles - 1);
  logic timeout_q, timeout_d;
`endif

  lcd_byte_arbiter_gap_timer #(
    .Width(CntW)
  ) u_gap_timer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .load_i   (tmr_load),
    .value_i  (tmr_value),
    .expired_o(tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    data_d    = data_q;
    rs_d      = rs_q;
    we_d      = 1'b0;
    nib_d     = 4'h0;
    tmr_load  = 1'b0;
    tmr_value = '0;
`ifdef LCD_ARB_TIMEOUT_EN
    timeout_d = timeout_q;
`endif
    // On a tie the port that was not served last wins.
    pick     = (req0_i && req1_i) ? ~last_q : req1_i;
    sel_data = pick ? data1_i : data0_i;

    unique case (state_q)
      StIdle: begin
        if (req0_i || req1_i) begin
          grant_d = pick;
          last_d  = pick;
          data_d  = sel_data;
          rs_d    = pick ? rs1_i : rs0_i;
          state_d = StHiWr;
          we_d    = 1'b1;
          nib_d   = sel_data[7:4];
`ifdef LCD_ARB_TIMEOUT_EN
          tmr_load  = 1'b1;
          tmr_value = TimeoutV;
`endif
        end
      end
      StHiWr: begin
        if (lcd_response_i) begin
          state_d   = StHiGap;
          tmr_load  = 1'b1;
          tmr_value = GapNibbleV;
        end
`ifdef LCD_ARB_TIMEOUT_EN
        else if (tmr_expired) begin
          state_d   = StDone;
          timeout_d = 1'b1;
        end
`endif
        else begin
          we_d  = 1'b1;
          nib_d = data_q[7:4];
        end
      end
      StHiGap: begin
        if (tmr_expired) begin
          state_d = StLoWr;
          we_d    = 1'b1;
          nib_d   = data_q[3:0];
`ifdef LCD_ARB_TIMEOUT_EN
          tmr_load  = 1'b1;
          tmr_value = TimeoutV;
`endif
        end
      end
      StLoWr: begin
        if (lcd_response_i) begin
          state_d   = StLoGap;
          tmr_load  = 1'b1;
          tmr_value = GapByteV;
        end
`ifdef LCD_ARB_TIMEOUT_EN
        else if (tmr_expired) begin
          state_d   = StDone;
          timeout_d = 1'b1;
        end
`endif
        else begin
          we_d  = 1'b1;
          nib_d = data_q[3:0];
        end
      end
      StLoGap: begin
        if (tmr_expired) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Outputs are registered from the next state so they line up with the state they describe.
    busy_d = (state_d != StIdle);
    ack0_d = (state_d == StDone) && (grant_d == LcdReqCpu);
    ack1_d = (state_d == StDone) && (grant_d == LcdReqAux);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      data_q  <= 8'h00;
      rs_q    <= 1'b0;
      busy_q  <= 1'b0;
      we_q    <= 1'b0;
      nib_q   <= 4'h0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      busy_q  <= busy_d;
      we_q    <= we_d;
      nib_q   <= nib_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
    end
  end

`ifdef LCD_ARB_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign ack0_o         = ack0_q;
  assign ack1_o         = ack1_q;
  assign grant_o        = grant_q;
  assign busy_o         = busy_q;
  assign lcd_data_o     = nib_q;
  assign lcd_rs_o       = rs_q;
  assign lcd_write_en_o = we_q;

endmodule
